// File: rtl/mem_wb_stage_if.sv
// MEM-to-WB bundle: pipeline controls, MEM-stage results in, register-file write port out.
// WB_BYPASS_EN adds the decode-read bypass signals.
interface mem_wb_stage_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
);
    logic              stall;
    logic              flush;
    logic              mem_valid;
    logic              mem_reg_write;
    logic              mem_mem_to_reg;
    logic [2:0]        mem_load_type;
    logic [1:0]        mem_addr_lo;
    logic [DATA_W-1:0] mem_alu_result;
    logic [DATA_W-1:0] mem_load_data;
    logic [4:0]        mem_write_reg;
    logic              wb_valid;
    logic              wb_reg_write;
    logic [4:0]        wb_write_reg;
    logic [DATA_W-1:0] wb_write_data;
    logic [CNT_W-1:0]  wb_retired;
`ifdef WB_BYPASS_EN
    logic [4:0]        rf_read_add1;
    logic [4:0]        rf_read_add2;
    logic [DATA_W-1:0] rf_data1;
    logic [DATA_W-1:0] rf_data2;
    logic [DATA_W-1:0] byp_data1;
    logic [DATA_W-1:0] byp_data2;

    modport master (
        output stall, flush, mem_valid, mem_reg_write, mem_mem_to_reg, mem_load_type,
               mem_addr_lo, mem_alu_result, mem_load_data, mem_write_reg,
               rf_read_add1, rf_read_add2, rf_data1, rf_data2,
        input  wb_valid, wb_reg_write, wb_write_reg, wb_write_data, wb_retired,
               byp_data1, byp_data2
    );
    modport slave (
        input  stall, flush, mem_valid, mem_reg_write, mem_mem_to_reg, mem_load_type,
               mem_addr_lo, mem_alu_result, mem_load_data, mem_write_reg,
               rf_read_add1, rf_read_add2, rf_data1, rf_data2,
        output wb_valid, wb_reg_write, wb_write_reg, wb_write_data, wb_retired,
               byp_data1, byp_data2
    );
`else
    modport master (
        output stall, flush, mem_valid, mem_reg_write, mem_mem_to_reg, mem_load_type,
               mem_addr_lo, mem_alu_result, mem_load_data, mem_write_reg,
        input  wb_valid, wb_reg_write, wb_write_reg, wb_write_data, wb_retired
    );
    modport slave (
        input  stall, flush, mem_valid, mem_reg_write, mem_mem_to_reg, mem_load_type,
               mem_addr_lo, mem_alu_result, mem_load_data, mem_write_reg,
        output wb_valid, wb_reg_write, wb_write_reg, wb_write_data, wb_retired
    );
`endif
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB register with load extraction, writeback select and retire counter; 1-cycle latency, stall holds.
// Optional macro WB_BYPASS_EN adds a combinational WB-to-decode register-read bypass.
module mem_wb_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic           clk,
    input  logic           reset,
    mem_wb_stage_if.slave  bus
);
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DATA_W-1:0] ld_val;
    logic [DATA_W-1:0] wr_data;
    logic              wr_en;

    always_comb begin
        ld_byte = bus.mem_load_data[7:0];
        case (bus.mem_addr_lo)
            2'd1:    ld_byte = bus.mem_load_data[15:8];
            2'd2:    ld_byte = bus.mem_load_data[23:16];
            2'd3:    ld_byte = bus.mem_load_data[31:24];
            default: ld_byte = bus.mem_load_data[7:0];
        endcase
        ld_half = bus.mem_addr_lo[1] ? bus.mem_load_data[31:16] : bus.mem_load_data[15:0];

        // Unassigned load codes fall back to a full-word load.
        case (bus.mem_load_type)
            3'b001:  ld_val = {{24{ld_byte[7]}}, ld_byte};
            3'b010:  ld_val = {24'd0, ld_byte};
            3'b011:  ld_val = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_val = {16'd0, ld_half};
            default: ld_val = bus.mem_load_data;
        endcase

        wr_data = bus.mem_mem_to_reg ? ld_val : bus.mem_alu_result;
        wr_en   = bus.mem_reg_write && (bus.mem_write_reg != 5'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.wb_valid      <= 1'b0;
            bus.wb_reg_write  <= 1'b0;
            bus.wb_write_reg  <= 5'd0;
            bus.wb_write_data <= '0;
            bus.wb_retired    <= '0;
        end else if (bus.flush) begin
            bus.wb_valid      <= 1'b0;
            bus.wb_reg_write  <= 1'b0;
            bus.wb_write_reg  <= 5'd0;
            bus.wb_write_data <= '0;
        end else if (!bus.stall) begin
            if (bus.mem_valid) begin
                bus.wb_valid      <= 1'b1;
                bus.wb_reg_write  <= wr_en;
                bus.wb_write_reg  <= bus.mem_write_reg;
                bus.wb_write_data <= wr_data;
                bus.wb_retired    <= bus.wb_retired + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                bus.wb_valid      <= 1'b0;
                bus.wb_reg_write  <= 1'b0;
                bus.wb_write_reg  <= 5'd0;
                bus.wb_write_data <= '0;
            end
        end
    end

`ifdef WB_BYPASS_EN
    // Register-file write and decode read land in the same cycle; forward the write.
    assign bus.byp_data1 = (bus.wb_reg_write && bus.rf_read_add1 != 5'd0 &&
                            bus.wb_write_reg == bus.rf_read_add1) ? bus.wb_write_data : bus.rf_data1;
    assign bus.byp_data2 = (bus.wb_reg_write && bus.rf_read_add2 != 5'd0 &&
                            bus.wb_write_reg == bus.rf_read_add2) ? bus.wb_write_data : bus.rf_data2;
`endif
endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: reference model compared every cycle plus directed literal checks.
module tb_mem_wb_stage;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    mem_wb_stage_if #(.DATA_W(32), .CNT_W(32)) bus ();
    mem_wb_stage_if #(.DATA_W(32), .CNT_W(4))  sbus ();

    mem_wb_stage #(.DATA_W(32), .CNT_W(32)) dut   (.clk(clk), .reset(reset), .bus(bus));
    mem_wb_stage #(.DATA_W(32), .CNT_W(4))  dut_s (.clk(clk), .reset(reset), .bus(sbus));

    // Narrow-counter copy sees exactly the same stimulus, so wrap can be exercised in 16 retires.
    assign sbus.stall          = bus.stall;
    assign sbus.flush          = bus.flush;
    assign sbus.mem_valid      = bus.mem_valid;
    assign sbus.mem_reg_write  = bus.mem_reg_write;
    assign sbus.mem_mem_to_reg = bus.mem_mem_to_reg;
    assign sbus.mem_load_type  = bus.mem_load_type;
    assign sbus.mem_addr_lo    = bus.mem_addr_lo;
    assign sbus.mem_alu_result = bus.mem_alu_result;
    assign sbus.mem_load_data  = bus.mem_load_data;
    assign sbus.mem_write_reg  = bus.mem_write_reg;
`ifdef WB_BYPASS_EN
    assign sbus.rf_read_add1   = bus.rf_read_add1;
    assign sbus.rf_read_add2   = bus.rf_read_add2;
    assign sbus.rf_data1       = bus.rf_data1;
    assign sbus.rf_data2       = bus.rf_data2;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Load result from the architectural definition: little-endian lane pick, then extension.
    function automatic logic [31:0] load_result(input logic [2:0] lt, input logic [1:0] lo,
                                                input logic [31:0] d);
        logic [31:0] v;
        case (lt)
            3'd1, 3'd2: begin
                v = (d >> (8 * lo)) & 32'hFF;
                if (lt == 3'd1 && v >= 32'h80) v = v | 32'hFFFF_FF00;
            end
            3'd3, 3'd4: begin
                v = (d >> (16 * lo[1])) & 32'hFFFF;
                if (lt == 3'd3 && v >= 32'h8000) v = v | 32'hFFFF_0000;
            end
            default: v = d;
        endcase
        return v;
    endfunction

    logic        e_valid, e_rw;
    logic [4:0]  e_reg;
    logic [31:0] e_data;
    logic [31:0] e_cnt;

    always @(posedge clk) begin
        if (reset) begin
            e_valid = 1'b0; e_rw = 1'b0; e_reg = 5'd0; e_data = 32'd0; e_cnt = 32'd0;
        end else if (bus.flush || (!bus.stall && !bus.mem_valid)) begin
            e_valid = 1'b0; e_rw = 1'b0; e_reg = 5'd0; e_data = 32'd0;
        end else if (!bus.stall) begin
            e_valid = 1'b1;
            e_rw    = bus.mem_reg_write && bus.mem_write_reg != 5'd0;
            e_reg   = bus.mem_write_reg;
            e_data  = bus.mem_mem_to_reg ?
                      load_result(bus.mem_load_type, bus.mem_addr_lo, bus.mem_load_data) :
                      bus.mem_alu_result;
            e_cnt   = e_cnt + 32'd1;
        end
        #1;
        chk("m_valid",   {31'd0, bus.wb_valid}, {31'd0, e_valid});
        chk("m_regwr",   {31'd0, bus.wb_reg_write}, {31'd0, e_rw});
        chk("m_wreg",    {27'd0, bus.wb_write_reg}, {27'd0, e_reg});
        chk("m_wdata",   bus.wb_write_data, e_data);
        chk("m_retired", bus.wb_retired, e_cnt);
        chk("m_retired4", {28'd0, sbus.wb_retired}, {28'd0, e_cnt[3:0]});
    end

`ifdef WB_BYPASS_EN
    always @(negedge clk) begin
        chk("m_byp1", bus.byp_data1, (e_rw && e_reg == bus.rf_read_add1 && bus.rf_read_add1 != 5'd0)
                                     ? e_data : bus.rf_data1);
        chk("m_byp2", bus.byp_data2, (e_rw && e_reg == bus.rf_read_add2 && bus.rf_read_add2 != 5'd0)
                                     ? e_data : bus.rf_data2);
    end
`endif

    task automatic set_mem(input logic v, input logic rw, input logic m2r, input logic [2:0] lt,
                           input logic [1:0] lo, input logic [31:0] alu, input logic [31:0] ld,
                           input logic [4:0] rd);
        bus.mem_valid      = v;
        bus.mem_reg_write  = rw;
        bus.mem_mem_to_reg = m2r;
        bus.mem_load_type  = lt;
        bus.mem_addr_lo    = lo;
        bus.mem_alu_result = alu;
        bus.mem_load_data  = ld;
        bus.mem_write_reg  = rd;
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    logic [2:0]  ld_type [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    logic [1:0]  ld_lo   [5] = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd2};
    logic [31:0] ld_exp  [5] = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_80FF,
                                 32'h0000_7F01, 32'h80FF_7F01};

    initial begin
        reset = 1'b1;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        set_mem(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 32'd0, 32'd0, 5'd0);
`ifdef WB_BYPASS_EN
        bus.rf_read_add1 = 5'd0; bus.rf_read_add2 = 5'd0;
        bus.rf_data1 = 32'd0;    bus.rf_data2 = 32'd0;
`endif
        cyc(); cyc();
        reset = 1'b0;
        cyc();
        chk("rst_valid", {31'd0, bus.wb_valid}, 32'd0);
        chk("rst_regwr", {31'd0, bus.wb_reg_write}, 32'd0);
        chk("rst_wdata", bus.wb_write_data, 32'd0);
        chk("rst_retired", bus.wb_retired, 32'd0);

        set_mem(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h1234_5678, 32'd0, 5'd5);
        cyc();
        chk("alu_regwr", {31'd0, bus.wb_reg_write}, 32'd1);
        chk("alu_wreg", {27'd0, bus.wb_write_reg}, 32'd5);
        chk("alu_wdata", bus.wb_write_data, 32'h1234_5678);
        chk("alu_retired", bus.wb_retired, 32'd1);

        for (int i = 0; i < 5; i++) begin
            set_mem(1'b1, 1'b1, 1'b1, ld_type[i], ld_lo[i], 32'hCAFE_0000, 32'h80FF_7F01, 5'd8);
            cyc();
            chk($sformatf("load_%0d", i), bus.wb_write_data, ld_exp[i]);
        end
        chk("load_retired", bus.wb_retired, 32'd6);

        set_mem(1'b1, 1'b1, 1'b1, 3'd7, 2'd1, 32'd0, 32'hA5A5_0F0F, 5'd8);
        cyc();
        chk("ltype7", bus.wb_write_data, 32'hA5A5_0F0F);

        set_mem(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0000_0042, 32'd0, 5'd0);
        cyc();
        chk("r0_regwr", {31'd0, bus.wb_reg_write}, 32'd0);
        chk("r0_valid", {31'd0, bus.wb_valid}, 32'd1);
        chk("r0_retired", bus.wb_retired, 32'd8);

        set_mem(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0000_AAAA, 32'd0, 5'd7);
        cyc();
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_mem(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0000_5555 + i, 32'd0, 5'd3);
            cyc();
            chk("stall_wdata", bus.wb_write_data, 32'h0000_AAAA);
            chk("stall_wreg", {27'd0, bus.wb_write_reg}, 32'd7);
            chk("stall_retired", bus.wb_retired, 32'd9);
        end
        bus.flush = 1'b1;
        cyc();
        chk("flush_valid", {31'd0, bus.wb_valid}, 32'd0);
        chk("flush_regwr", {31'd0, bus.wb_reg_write}, 32'd0);
        chk("flush_wdata", bus.wb_write_data, 32'd0);
        chk("flush_retired", bus.wb_retired, 32'd9);
        bus.flush = 1'b0;
        bus.stall = 1'b0;

        set_mem(1'b0, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0000_1111, 32'd0, 5'd4);
        cyc();
        chk("bubble_valid", {31'd0, bus.wb_valid}, 32'd0);
        chk("bubble_regwr", {31'd0, bus.wb_reg_write}, 32'd0);
        chk("bubble_retired", bus.wb_retired, 32'd9);

`ifdef WB_BYPASS_EN
        set_mem(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'hDEAD_BEEF, 32'd0, 5'd9);
        cyc();
        bus.rf_read_add1 = 5'd9; bus.rf_data1 = 32'd0;
        bus.rf_read_add2 = 5'd0; bus.rf_data2 = 32'h1111_2222;
        #1;
        chk("byp1_hit", bus.byp_data1, 32'hDEAD_BEEF);
        chk("byp2_r0", bus.byp_data2, 32'h1111_2222);
        bus.rf_read_add1 = 5'd10; bus.rf_data1 = 32'h3333_4444;
        #1;
        chk("byp1_miss", bus.byp_data1, 32'h3333_4444);
`endif

        set_mem(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0000_0077, 32'd0, 5'd6);
        cyc();
        chk("pre_rst_regwr", {31'd0, bus.wb_reg_write}, 32'd1);
        reset = 1'b1;
        cyc();
        chk("mid_rst_regwr", {31'd0, bus.wb_reg_write}, 32'd0);
        chk("mid_rst_wreg", {27'd0, bus.wb_write_reg}, 32'd0);
        chk("mid_rst_retired", bus.wb_retired, 32'd0);
        reset = 1'b0;

        set_mem(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0000_0001, 32'd0, 5'd2);
        repeat (16) cyc();
        chk("wrap_retired32", bus.wb_retired, 32'd16);
        chk("wrap_retired4", {28'd0, sbus.wb_retired}, 32'd0);
        cyc();
        chk("wrap_after", {28'd0, sbus.wb_retired}, 32'd1);

        set_mem(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 32'd0, 32'd0, 5'd0);
        cyc(); cyc();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
